he_lut_apply: RTL and testbench

//  Stage after the histogram-equalisation LUT calculator. Captures the 256-entry

---
 rtl/he_lut_apply.sv | 119 +++++++++++
 tb/tb_he_lut_apply.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/he_lut_apply.sv
// Captures a 256-entry equalisation LUT, then remaps a pixel stream through it (dst = lut[src]).
// One cycle from accept to output; input stalls while an unconsumed output is held.
module he_lut_apply #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 21,
  parameter int NUM_BINS  = 256,
  parameter int TOTAL_PIX = 1091840
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              lut_wr_en,
  input  logic [AWIDTH-1:0] lut_din,
  input  logic              pix_in_valid,
  input  logic [DWIDTH-1:0] pix_in_data,
  output logic              pix_in_ready,
  output logic              pix_out_valid,
  output logic [DWIDTH-1:0] pix_out_data,
  input  logic              pix_out_ready,
  output logic              lut_ovf,
  output logic              done,
  output logic [3:0]        state
);

  localparam int                LCW      = $clog2(NUM_BINS) + 1;
  localparam logic [AWIDTH-1:0] LUT_MAX  = AWIDTH'((1 << DWIDTH) - 1);
  localparam logic [LCW-1:0]    LAST_BIN = LCW'(NUM_BINS - 1);
  localparam logic [AWIDTH-1:0] LAST_PIX = AWIDTH'(TOTAL_PIX - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    LOAD  = 4'b0010,
    APPLY = 4'b0100,
    FLUSH = 4'b1000
  } state_t;

  state_t            state_q;
  logic [LCW-1:0]    load_cnt;
  logic [AWIDTH-1:0] pix_cnt;
  logic [DWIDTH-1:0] lut [NUM_BINS];

  logic              out_free;
  logic              accept;
  logic              lut_we;
  logic              clamp;
  logic [DWIDTH-1:0] lut_wdat;

  assign out_free     = !pix_out_valid || pix_out_ready;
  assign pix_in_ready = (state_q == APPLY) && out_free;
  assign accept       = pix_in_valid && pix_in_ready;
  assign lut_we       = (state_q == LOAD) && lut_wr_en;
  assign clamp        = lut_din > LUT_MAX;
  assign lut_wdat     = clamp ? LUT_MAX[DWIDTH-1:0] : lut_din[DWIDTH-1:0];
  assign state        = state_q;

  // LUT storage has no reset; every frame rewrites all bins before APPLY.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut[load_cnt[LCW-2:0]] <= lut_wdat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      load_cnt      <= '0;
      pix_cnt       <= '0;
      pix_out_valid <= 1'b0;
      pix_out_data  <= '0;
      lut_ovf       <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= LOAD;
            load_cnt <= '0;
            pix_cnt  <= '0;
            lut_ovf  <= 1'b0;
          end
        end
        LOAD: begin
          if (lut_wr_en) begin
            load_cnt <= load_cnt + LCW'(1);
            if (clamp) begin
              lut_ovf <= 1'b1;
            end
            if (load_cnt == LAST_BIN) begin
              state_q <= APPLY;
            end
          end
        end
        APPLY: begin
          if (accept) begin
            pix_out_data  <= lut[pix_in_data];
            pix_out_valid <= 1'b1;
            pix_cnt       <= pix_cnt + AWIDTH'(1);
            if (pix_cnt == LAST_PIX) begin
              state_q <= FLUSH;
            end
          end else if (pix_out_valid && pix_out_ready) begin
            pix_out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          // Last pixel must leave before the frame is reported complete.
          if (out_free) begin
            pix_out_valid <= 1'b0;
            done          <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_he_lut_apply.sv
// Directed bench for he_lut_apply with a 16-pixel frame: table of frames plus a reset-mid-frame sequence.
module tb_he_lut_apply;

  localparam int DW = 8;
  localparam int AW = 21;
  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          lut_wr_en;
  logic [AW-1:0] lut_din;
  logic          pix_in_valid;
  logic [DW-1:0] pix_in_data;
  logic          pix_in_ready;
  logic          pix_out_valid;
  logic [DW-1:0] pix_out_data;
  logic          pix_out_ready;
  logic          lut_ovf;
  logic          done;
  logic [3:0]    state;

  he_lut_apply #(.DWIDTH(DW), .AWIDTH(AW), .NUM_BINS(256), .TOTAL_PIX(NP)) dut (
    .clk(clk), .reset(reset), .start(start), .lut_wr_en(lut_wr_en), .lut_din(lut_din),
    .pix_in_valid(pix_in_valid), .pix_in_data(pix_in_data), .pix_in_ready(pix_in_ready),
    .pix_out_valid(pix_out_valid), .pix_out_data(pix_out_data), .pix_out_ready(pix_out_ready),
    .lut_ovf(lut_ovf), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                    lut_mode;   // 0 identity, 1 inverted, 2 only bin 5 = 300
    int                    gap;        // idle cycles between LUT writes
    int                    stall_at;
    int                    stall_len;
    bit                    noise;      // drive start/lut_wr_en during APPLY
    int                    exp_iters;
    bit                    exp_ovf;
    logic [NP-1:0][DW-1:0] pix;
    logic [NP-1:0][DW-1:0] exp;
  } frame_t;

  frame_t frames [5];
  int     nchk = 0;
  int     nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("state_load", state, 4'b0010);
    chk("ovf_cleared", lut_ovf, 0);
  endtask

  task automatic load_lut(input int mode, input int gap);
    int bad_rdy = 0;
    int bad_state = 0;
    int val;
    pix_in_valid = 1'b1;
    pix_in_data  = 8'd5;
    for (int i = 0; i < 256; i++) begin
      for (int g = 0; g < gap; g++) begin
        lut_wr_en = 1'b0;
        #1;
        if (pix_in_ready !== 1'b0) bad_rdy++;
        @(posedge clk); @(negedge clk);
        if (state !== 4'b0010) bad_state++;
      end
      val = (mode == 0) ? i : (mode == 1) ? 255 - i : (i == 5) ? 300 : 0;
      lut_wr_en = 1'b1;
      lut_din   = AW'(val);
      #1;
      if (pix_in_ready !== 1'b0) bad_rdy++;
      @(posedge clk); @(negedge clk);
      if (i < 255 && state !== 4'b0010) bad_state++;
    end
    lut_wr_en    = 1'b0;
    pix_in_valid = 1'b0;
    chk("load_in_ready_low", bad_rdy, 0);
    chk("load_state_held", bad_state, 0);
    chk("state_apply", state, 4'b0100);
  endtask

  task automatic run_stream(input frame_t f);
    int            sent = 0;
    int            recv = 0;
    int            it = 0;
    bit            got_done = 0;
    bit            stall;
    logic [DW-1:0] held = '0;
    while (!got_done && it < 100) begin
      stall         = (f.stall_len > 0) && (it >= f.stall_at) && (it < f.stall_at + f.stall_len);
      pix_out_ready = !stall;
      pix_in_valid  = (sent < NP);
      pix_in_data   = (sent < NP) ? f.pix[sent] : '0;
      start         = f.noise;
      lut_wr_en     = f.noise;
      lut_din       = '0;
      #1;
      if (stall && pix_out_valid) begin
        if (it == f.stall_at) held = pix_out_data;
        else chk("stall_data_hold", pix_out_data, held);
        chk("stall_in_ready", pix_in_ready, 0);
      end
      if (pix_out_valid && pix_out_ready) begin
        if (recv < NP) chk("pix_out", pix_out_data, f.exp[recv]);
        recv++;
      end
      if (pix_in_valid && pix_in_ready) sent++;
      @(posedge clk); @(negedge clk);
      it++;
      if (done) got_done = 1;
    end
    start = 1'b0; lut_wr_en = 1'b0; pix_in_valid = 1'b0; pix_out_ready = 1'b1;
    chk("done_seen", got_done, 1);
    chk("frame_cycles", it, f.exp_iters);
    chk("outputs_count", recv, NP);
    chk("inputs_count", sent, NP);
    chk("state_idle", state, 4'b0001);
    chk("lut_ovf", lut_ovf, f.exp_ovf);
    @(posedge clk); @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_frame(input frame_t f);
    start_frame();
    load_lut(f.lut_mode, f.gap);
    run_stream(f);
  endtask

  initial begin
    logic [DW-1:0] inv_pix [NP] = '{0, 1, 2, 3, 10, 20, 30, 40, 100, 127, 128, 200, 250, 254, 255, 7};
    logic [DW-1:0] inv_exp [NP] = '{255, 254, 253, 252, 245, 235, 225, 215, 155, 128, 127, 55, 5, 1, 0, 248};
    int acc;

    frames[0] = '{lut_mode:0, gap:0, stall_at:0, stall_len:0, noise:0, exp_iters:17, exp_ovf:0, pix:'0, exp:'0};
    frames[1] = '{lut_mode:2, gap:0, stall_at:0, stall_len:0, noise:0, exp_iters:17, exp_ovf:1, pix:'0, exp:'0};
    frames[2] = '{lut_mode:1, gap:0, stall_at:5, stall_len:3, noise:0, exp_iters:20, exp_ovf:0, pix:'0, exp:'0};
    frames[3] = '{lut_mode:1, gap:2, stall_at:0, stall_len:0, noise:0, exp_iters:17, exp_ovf:0, pix:'0, exp:'0};
    frames[4] = '{lut_mode:1, gap:0, stall_at:0, stall_len:0, noise:1, exp_iters:17, exp_ovf:0, pix:'0, exp:'0};
    for (int i = 0; i < NP; i++) begin
      frames[0].pix[i] = DW'(i);
      frames[0].exp[i] = DW'(i);
      frames[1].pix[i] = (i % 2 == 0) ? 8'd5 : 8'd6;
      frames[1].exp[i] = (i % 2 == 0) ? 8'd255 : 8'd0;
      for (int k = 2; k < 5; k++) begin
        frames[k].pix[i] = inv_pix[i];
        frames[k].exp[i] = inv_exp[i];
      end
    end

    reset = 1'b1; start = 1'b0; lut_wr_en = 1'b0; lut_din = '0;
    pix_in_valid = 1'b0; pix_in_data = '0; pix_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state, 4'b0001);
    chk("rst_out_valid", pix_out_valid, 0);
    chk("rst_out_data", pix_out_data, 0);
    chk("rst_in_ready", pix_in_ready, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    for (int k = 0; k < 5; k++) run_frame(frames[k]);

    // Reset in the middle of APPLY after 7 accepted pixels, with lut_ovf set.
    start_frame();
    load_lut(2, 0);
    acc = 0;
    for (int c = 0; c < 30 && acc < 7; c++) begin
      pix_in_valid = 1'b1;
      pix_in_data  = (acc % 2 == 0) ? 8'd5 : 8'd6;
      #1;
      if (pix_in_ready) acc++;
      @(posedge clk); @(negedge clk);
    end
    pix_in_valid = 1'b0;
    chk("mid_accepted", acc, 7);
    chk("mid_ovf_set", lut_ovf, 1);
    chk("mid_out_valid", pix_out_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_state", state, 4'b0001);
    chk("mid_rst_out_valid", pix_out_valid, 0);
    chk("mid_rst_out_data", pix_out_data, 0);
    chk("mid_rst_in_ready", pix_in_ready, 0);
    chk("mid_rst_ovf", lut_ovf, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    run_frame(frames[0]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
